// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch resolution slice.
package branch_pkg;

  localparam int BR_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } br_entry_t;

endpackage

// File: rtl/br_pred_fifo.sv
// Circular FIFO of in-flight branch predictions with flush; head is combinational.
module br_pred_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH_DEFAULT
) (
  input  logic      clk_i,
  input  logic      rst_n,
  input  logic      push,
  input  br_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output logic      full,
  output logic      empty,
  output br_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  br_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks in-order BRU results against queued predictions; drives predictor update and redirect.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [31:0]      pred_PC,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic             res_valid,
  input  logic [31:0]      res_PC,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             br_update,
  output logic             br_update_taken,
  output logic [31:0]      br_update_PC,
  output logic [31:0]      br_update_target,
  output logic             mispredict,
  output logic [31:0]      redirect_PC,
  output logic             order_err,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  br_entry_t push_data;
  br_entry_t head;
  logic      full;
  logic      empty;
  logic      accept;
  logic      mis;

  assign push_data  = '{pc: pred_PC, taken: pred_taken, target: pred_target};
  assign pred_ready = ~full;
  assign accept     = res_valid & ~empty;
  assign mis        = (res_taken != head.taken) |
                      (res_taken & head.taken & (res_target != head.target));

  // A mispredict flushes every younger entry, including anything arriving this cycle.
  br_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .push      (pred_valid & pred_ready),
    .push_data (push_data),
    .pop       (accept),
    .flush     (accept & mis),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      br_update        <= 1'b0;
      br_update_taken  <= 1'b0;
      br_update_PC     <= '0;
      br_update_target <= '0;
      mispredict       <= 1'b0;
      redirect_PC      <= '0;
      order_err        <= 1'b0;
      br_count         <= '0;
      mispred_count    <= '0;
    end else begin
      br_update  <= accept;
      mispredict <= accept & mis;
      if (accept) begin
        br_update_taken  <= res_taken;
        br_update_PC     <= res_PC;
        br_update_target <= res_target;
        if (br_count != {CNT_W{1'b1}}) br_count <= br_count + CNT_W'(1);
      end
      if (accept & mis) begin
        redirect_PC <= res_taken ? res_target : res_PC + 32'd4;
        if (mispred_count != {CNT_W{1'b1}}) mispred_count <= mispred_count + CNT_W'(1);
      end
      if ((res_valid & empty) | (accept & (res_PC != head.pc))) order_err <= 1'b1;
    end
  end

endmodule
